// File: rtl/gates_vector_sequencer.sv
// Closed-loop stimulus/response sequencer for the GATES block.
// Walks A/B through the Gray-ordered vectors 00,01,11,10, holds each one for
// SETTLE cycles, then spends one CHECK cycle comparing Y1..Y6 against the
// truth table. Reports a saturating error count, a sticky per-gate fail mask
// and PASS/DONE.
module gates_vector_sequencer #(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1,
    parameter int ERR_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             y1_i,
    input  logic             y2_i,
    input  logic             y3_i,
    input  logic             y4_i,
    input  logic             y5_i,
    input  logic             y6_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [5:0]       fail_mask_o,
    output logic [1:0]       vec_idx_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [7:0]       LOOPS_M1  = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [7:0]       loop_q, loop_d;
    logic [1:0]       vec_q, vec_d;
    logic             a_q, a_d, b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [5:0]       mask_q, mask_d;

    logic [5:0] y_obs, y_exp, mism;
    logic [1:0] vec_nx;

    // Next-state, vector sequencing and result accumulation.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        loop_d   = loop_q;
        vec_d    = vec_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        mask_d   = mask_q;

        y_obs  = {y6_i, y5_i, y4_i, y3_i, y2_i, y1_i};
        y_exp  = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
        mism   = y_obs ^ y_exp;
        vec_nx = vec_q + 2'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_DRIVE;
                    settle_d = '0;
                    loop_d   = '0;
                    vec_d    = '0;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    err_d    = '0;
                    mask_d   = '0;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_M1) begin
                    state_d  = S_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (|mism && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                mask_d = mask_q | mism;
                if (vec_q == 2'd3 && loop_q == LOOPS_M1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_nx;
                    // Gray order: idx 0..3 -> AB 00,01,11,10
                    a_d     = vec_nx[1];
                    b_d     = vec_nx[1] ^ vec_nx[0];
                    if (vec_q == 2'd3) loop_d = loop_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            loop_q   <= '0;
            vec_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            loop_q   <= loop_d;
            vec_q    <= vec_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign busy_o      = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = (state_q == S_DONE) && (err_q == '0);
    assign err_cnt_o   = err_q;
    assign fail_mask_o = mask_q;
    assign vec_idx_o   = vec_q;

endmodule

// File: tb/tb_gates_vector_sequencer.sv
// Bench for gates_vector_sequencer: a behavioural GATES model with
// programmable per-vector faults drives Y, and a run-level reference model
// predicts error count, fail mask and PASS.
module tb_gates_vector_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-vector XOR fault applied on top of the ideal gates, indexed by {A,B}.
    logic [5:0] flip_tab [4];

    function automatic logic [5:0] truth(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    // dut1: SETTLE=2, LOOPS=1, ERR_W=4
    logic a1, b1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [5:0] mask1, y1v;
    logic [1:0] vec1;
    // dut3: SETTLE=2, LOOPS=3, ERR_W=2
    logic a3, b3, busy3, done3, pass3;
    logic [1:0] err3;
    logic [5:0] mask3, y3v;
    logic [1:0] vec3;

    assign y1v = truth(a1, b1) ^ flip_tab[{a1, b1}];
    assign y3v = truth(a3, b3) ^ flip_tab[{a3, b3}];

    gates_vector_sequencer #(.SETTLE(2), .LOOPS(1), .ERR_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .y1_i(y1v[0]), .y2_i(y1v[1]), .y3_i(y1v[2]), .y4_i(y1v[3]), .y5_i(y1v[4]), .y6_i(y1v[5]),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err1), .fail_mask_o(mask1), .vec_idx_o(vec1)
    );

    gates_vector_sequencer #(.SETTLE(2), .LOOPS(3), .ERR_W(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .y1_i(y3v[0]), .y2_i(y3v[1]), .y3_i(y3v[2]), .y4_i(y3v[3]), .y5_i(y3v[4]), .y6_i(y3v[5]),
        .a_o(a3), .b_o(b3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .err_cnt_o(err3), .fail_mask_o(mask3), .vec_idx_o(vec3)
    );

    // Reference: walk the vector list LOOPS times, count mismatching vectors.
    function automatic void model_run(input int loops, input int sat,
                                      output int err, output logic [5:0] mask);
        logic [1:0] order [4];
        logic [5:0] m;
        order = '{2'b00, 2'b01, 2'b11, 2'b10};
        err = 0;
        mask = '0;
        for (int l = 0; l < loops; l++)
            for (int v = 0; v < 4; v++) begin
                m = flip_tab[order[v]];
                if (m != 0 && err < sat) err++;
                mask |= m;
            end
    endfunction

    function automatic logic [1:0] vec_ab(input int v);
        logic [1:0] order [4];
        order = '{2'b00, 2'b01, 2'b11, 2'b10};
        return order[v];
    endfunction

    task automatic do_reset();
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_flips(input logic [5:0] f0, input logic [5:0] f1,
                             input logic [5:0] f2, input logic [5:0] f3);
        flip_tab[0] = f0; flip_tab[1] = f1; flip_tab[2] = f2; flip_tab[3] = f3;
    endtask

    // Full run on dut1: start after the current edge, check every cycle.
    task automatic run_full(input string name);
        int exp_err;
        logic [5:0] exp_mask;
        logic [1:0] ab;
        model_run(1, 15, exp_err, exp_mask);
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c <= 12) begin
                ab = vec_ab((c - 1) / 3);
                checks++;
                if ({a1, b1, vec1, busy1, done1} !== {ab, 2'((c - 1) / 3), 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL %s cyc%0d ab/vec/busy/done got %b%b/%0d/%b/%b want %b/%0d/1/0",
                             name, c, a1, b1, vec1, busy1, done1, ab, (c - 1) / 3);
                end
            end
        end
        checks++;
        if ({done1, busy1, a1, b1, vec1} !== {1'b1, 1'b0, 2'b10, 2'd3}) begin
            errors++;
            $display("FAIL %s done-state done/busy/ab/vec got %b/%b/%b%b/%0d want 1/0/10/3",
                     name, done1, busy1, a1, b1, vec1);
        end
        checks++;
        if (err1 !== 4'(exp_err) || mask1 !== exp_mask || pass1 !== (exp_err == 0)) begin
            errors++;
            $display("FAIL %s result err/mask/pass got %0d/%b/%b want %0d/%b/%b",
                     name, err1, mask1, pass1, exp_err, exp_mask, exp_err == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a1, b1, busy1, done1, pass1, err1, mask1, vec1} !== '0 ||
            {a3, b3, busy3, done3, pass3, err3, mask3, vec3} !== '0) begin
            errors++;
            $display("FAIL reset dut1 %b%b%b%b%b/%0d/%b/%0d dut3 %b%b%b%b%b/%0d/%b/%0d want all 0",
                     a1, b1, busy1, done1, pass1, err1, mask1, vec1,
                     a3, b3, busy3, done3, pass3, err3, mask3, vec3);
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, a1, b1} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_hold busy/done/ab got %b/%b/%b%b want 0/0/00", busy1, done1, a1, b1);
        end
    endtask

    task automatic test_clean();
        set_flips('0, '0, '0, '0);
        do_reset();
        run_full("clean");
    endtask

    task automatic test_y5_stuck();
        set_flips(truth(0, 0) & 6'b010000, truth(0, 1) & 6'b010000,
                  truth(1, 0) & 6'b010000, truth(1, 1) & 6'b010000);
        do_reset();
        run_full("y5_stuck");
    endtask

    task automatic test_inverted();
        set_flips(6'h3F, 6'h3F, 6'h3F, 6'h3F);
        do_reset();
        run_full("inverted");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            for (int v = 0; v < 4; v++)
                flip_tab[v] = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom);
            do_reset();
            run_full($sformatf("random%0d", i));
        end
    endtask

    // Three loops with a 2-bit counter: error count must saturate.
    task automatic test_loops();
        int exp_err;
        logic [5:0] exp_mask;
        set_flips(truth(0, 0) & 6'b010000, truth(0, 1) & 6'b010000,
                  truth(1, 0) & 6'b010000, truth(1, 1) & 6'b010000);
        model_run(3, 3, exp_err, exp_mask);
        do_reset();
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 13 || c == 36 || c == 37) begin
                checks++;
                if (done3 !== (c == 37) || busy3 !== (c != 37)) begin
                    errors++;
                    $display("FAIL loops cyc%0d done/busy got %b/%b want %b/%b",
                             c, done3, busy3, c == 37, c != 37);
                end
            end
            if (c == 13) begin
                checks++;
                if ({a3, b3, vec3} !== 4'b0000) begin
                    errors++;
                    $display("FAIL loops wrap cyc13 ab/vec got %b%b/%0d want 00/0", a3, b3, vec3);
                end
            end
        end
        checks++;
        if (err3 !== 2'(exp_err) || mask3 !== exp_mask || pass3 !== 1'b0) begin
            errors++;
            $display("FAIL loops result err/mask/pass got %0d/%b/%b want %0d/%b/0",
                     err3, mask3, pass3, exp_err, exp_mask);
        end
    endtask

    // START during a run is ignored; START in DONE restarts with cleared results.
    task automatic test_start_ignored();
        set_flips(6'h3F, 6'h3F, 6'h3F, 6'h3F);
        do_reset();
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            start = (c == 4 || c == 8);
            if (c == 12 || c == 13) begin
                checks++;
                if (done1 !== (c == 13)) begin
                    errors++;
                    $display("FAIL start_busy cyc%0d done got %b want %b", c, done1, c == 13);
                end
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({done1, err1, mask1, pass1} !== {1'b1, 4'd4, 6'h3F, 1'b0}) begin
            errors++;
            $display("FAIL done_hold done/err/mask/pass got %b/%0d/%b/%b want 1/4/111111/0",
                     done1, err1, mask1, pass1);
        end
        // START held for two cycles in DONE: restart once, second cycle ignored.
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy1, done1, err1, mask1, vec1, a1, b1} !== {1'b1, 1'b0, 4'd0, 6'h00, 2'd0, 2'b00}) begin
            errors++;
            $display("FAIL restart busy/done/err/mask/vec/ab got %b/%b/%0d/%b/%0d/%b%b want 1/0/0/0/0/00",
                     busy1, done1, err1, mask1, vec1, a1, b1);
        end
        @(posedge clk); #1 start = 1'b0;
        for (int c = 3; c <= 13; c++) @(posedge clk);
        #1;
        checks++;
        if ({done1, err1} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL restart_end done/err got %b/%0d want 1/4", done1, err1);
        end
    endtask

    task automatic test_rst_mid();
        set_flips(6'h3F, 6'h3F, 6'h3F, 6'h3F);
        do_reset();
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        checks++;
        if (err1 !== 4'd1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_run err/busy got %0d/%b want 1/1", err1, busy1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a1, b1, busy1, done1, err1, mask1, vec1} !== '0) begin
            errors++;
            $display("FAIL rst_mid ab/busy/done/err/mask/vec got %b%b/%b/%b/%0d/%b/%0d want 0",
                     a1, b1, busy1, done1, err1, mask1, vec1);
        end
        rst = 1'b0;
        run_full("after_rst");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_y5_stuck();
        test_inverted();
        test_random();
        test_loops();
        test_start_ignored();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
